// File: rtl/div_seq.sv
// div_seq: sequential radix-2 restoring divider, quotient to lo and remainder to hi, with divide-by-zero flag.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  logic [1:0]       st_q, st_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
  logic             sq_q, sq_d, sr_q, sr_d, done_q, done_d, div0_q, div0_d;
  logic             go;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sh, trial;
  // The shifted partial remainder keeps its carry-out bit so large unsigned divisors stay exact.
  assign go    = (st_q == IDLE) && start_i;
  assign mag_a = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  assign sh    = {rem_q, dvd_q[WIDTH-1]};
  assign trial = sh - {1'b0, dvs_q};
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    sq_d   = sq_q;
    sr_d   = sr_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
    div0_d = go ? (b_i == '0) : div0_q;
    if (go) begin
      done_d = (b_i == '0);
      if (b_i != '0) begin
        st_d  = CALC;
        cnt_d = '0;
        rem_d = '0;
        dvd_d = mag_a;
        dvs_d = mag_b;
        sq_d  = is_signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
        sr_d  = is_signed_i && a_i[WIDTH-1];
      end
    end else if (st_q == CALC) begin
      rem_d = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
      dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
      cnt_d = cnt_q + 1'b1;
      st_d  = (cnt_q == CW'(WIDTH-1)) ? FIX : CALC;
    end else if (st_q == FIX) begin
      lo_d   = sq_q ? -dvd_q : dvd_q;
      hi_d   = sr_q ? -rem_q : rem_q;
      done_d = 1'b1;
      st_d   = IDLE;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      sq_q   <= 1'b0;
      sr_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      sq_q   <= sq_d;
      sr_q   <= sr_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      div0_q <= div0_d;
    end
  end
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = (st_q != IDLE);
  assign done_o = done_q;
  assign div0_o = div0_q;
endmodule
